// File: rtl/load_fanout_pkg.sv
// Shared constants for the load fan-out broadcast block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package load_fanout_pkg;

  // Default payload width in bits.
  localparam int DATA_W_DEF    = 8;
  // Default number of broadcast consumers (legal range 2..8).
  localparam int NUM_LOADS_DEF = 3;
  // Width of the retired-word counter; it wraps silently at its maximum.
  localparam int RETIRE_CNT_W  = 16;

  typedef logic [RETIRE_CNT_W-1:0] retire_cnt_t;

  // Wrapping increment of the retire counter.
  function automatic retire_cnt_t retire_cnt_inc(input retire_cnt_t cnt);
    return cnt + retire_cnt_t'(1);
  endfunction

endpackage

// File: rtl/load_fanout_bcast_skid.sv
// Two-entry head/skid store feeding the broadcast stage.
// Latency: one cycle from input acceptance into an empty store to head valid.
// Backpressure: in_rdy_o is registered and low exactly while the skid entry is occupied.
module fanout_skid_buf
  import load_fanout_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld_i,
  input  logic [DATA_W-1:0] in_dat_i,
  output logic              in_rdy_o,
  output logic              out_vld_o,
  output logic [DATA_W-1:0] out_dat_o,
  input  logic              out_rdy_i
);

  logic              head_vld_q, head_vld_d;
  logic [DATA_W-1:0] head_dat_q, head_dat_d;
  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
  logic              in_rdy_q,   in_rdy_d;
  logic              accept;
  logic              pop;

  // Input is taken only against the registered ready; pop only when a head exists.
  assign accept = in_vld_i & in_rdy_q;
  assign pop    = out_rdy_i & head_vld_q;

  // Next-state for head/skid: skid always drains into head first so order is kept.
  always_comb begin
    head_vld_d = head_vld_q;
    head_dat_d = head_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;

    if (pop) begin
      if (skid_vld_q) begin
        // Older skid word moves up; a concurrent arrival refills the skid slot.
        head_vld_d = 1'b1;
        head_dat_d = skid_dat_q;
        skid_vld_d = accept;
        if (accept) begin
          skid_dat_d = in_dat_i;
        end
      end else if (accept) begin
        // Skid empty: the arriving word goes straight to head, skid stays empty.
        head_vld_d = 1'b1;
        head_dat_d = in_dat_i;
      end else begin
        head_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!head_vld_q) begin
        head_vld_d = 1'b1;
        head_dat_d = in_dat_i;
      end else begin
        // Head busy and not leaving: park the word in skid.
        skid_vld_d = 1'b1;
        skid_dat_d = in_dat_i;
      end
    end

    // Ready for the next cycle mirrors skid emptiness after this update.
    in_rdy_d = !skid_vld_d;
  end

  // State registers; reset empties both entries and reopens the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_vld_q <= 1'b0;
      head_dat_q <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
      in_rdy_q   <= 1'b1;
    end else begin
      head_vld_q <= head_vld_d;
      head_dat_q <= head_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      in_rdy_q   <= in_rdy_d;
    end
  end

  assign in_rdy_o  = in_rdy_q;
  assign out_vld_o = head_vld_q;
  assign out_dat_o = head_dat_q;

endmodule

// File: rtl/load_fanout_bcast.sv
// Broadcasts each accepted word to NUM_LOADS consumers that may accept independently.
// Latency: one cycle from input acceptance (empty block) to out_valid; no in_* to out_* path.
// Backpressure: a word retires only once every load has taken it; in_ready drops when both entries are full.
module load_fanout_bcast
  import load_fanout_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_LOADS = NUM_LOADS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  output logic [NUM_LOADS-1:0]    out_valid,
  output logic [DATA_W-1:0]       out_data,
  input  logic [NUM_LOADS-1:0]    out_ready,
  output logic [RETIRE_CNT_W-1:0] retire_cnt
);

  logic                 head_vld;
  logic [DATA_W-1:0]    head_dat;
  logic [NUM_LOADS-1:0] taken_q, taken_d;
  logic [NUM_LOADS-1:0] xfer;
  logic                 retire;
  retire_cnt_t          retire_cnt_q, retire_cnt_d;

  fanout_skid_buf #(
    .DATA_W (DATA_W)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .in_vld_i  (in_valid),
    .in_dat_i  (in_data),
    .in_rdy_o  (in_ready),
    .out_vld_o (head_vld),
    .out_dat_o (head_dat),
    .out_rdy_i (retire)
  );

  // A load sees the head until it has taken it; ready on a masked load is ignored.
  assign out_valid = {NUM_LOADS{head_vld}} & ~taken_q;
  assign out_data  = head_dat;
  assign xfer      = out_valid & out_ready;

  // Head retires when every load has either taken it earlier or takes it now.
  assign retire = head_vld & (&(taken_q | xfer));

  // Taken bits accumulate per load and clear together when the head retires.
  always_comb begin
    taken_d      = taken_q | xfer;
    retire_cnt_d = retire_cnt_q;
    if (retire) begin
      taken_d      = '0;
      retire_cnt_d = retire_cnt_inc(retire_cnt_q);
    end
  end

  // Taken tracking and retire counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_q      <= '0;
      retire_cnt_q <= '0;
    end else begin
      taken_q      <= taken_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_load_fanout_bcast.sv
module tb_load_fanout_bcast;

  localparam int DW = 8;
  localparam int NL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [NL-1:0] out_valid;
  logic [DW-1:0] out_data;
  logic [NL-1:0] out_ready;
  logic [15:0]   retire_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_fanout_bcast #(
    .DATA_W    (DW),
    .NUM_LOADS (NL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .retire_cnt (retire_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: list of every word accepted since reset, how many words
  // each load has received, and how many words have been retired.
  logic [DW-1:0] acc[$];
  int            retired;
  int            dcnt[NL];
  int            rc_model;

  always @(negedge clk) begin : model
    logic [NL-1:0] exp_ov;
    int            occ;
    bit            all_done;
    if (rst) begin
      acc.delete();
      retired  = 0;
      rc_model = 0;
      for (int i = 0; i < NL; i++) dcnt[i] = 0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_retire_cnt", 32'(retire_cnt), 32'd0);
    end else begin
      occ    = acc.size() - retired;
      exp_ov = '0;
      for (int i = 0; i < NL; i++) begin
        if (occ > 0 && dcnt[i] == retired) exp_ov[i] = 1'b1;
      end
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("in_ready", 32'(in_ready), 32'(occ < 2));
      chk("retire_cnt", 32'(retire_cnt), 32'(rc_model % 65536));
      if (occ > 0) chk("out_data", 32'(out_data), 32'(acc[retired]));
      // Effects of the coming rising edge.
      for (int i = 0; i < NL; i++) begin
        if (exp_ov[i] && out_ready[i]) dcnt[i]++;
      end
      all_done = (occ > 0);
      for (int i = 0; i < NL; i++) begin
        if (dcnt[i] <= retired) all_done = 0;
      end
      if (all_done) begin
        retired++;
        rc_model = (rc_model + 1) % 65536;
      end
      if (in_valid && occ < 2) acc.push_back(in_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = '0;
    step();
    step();
    chk("lit_rst_out_valid", 32'(out_valid), 32'd0);
    chk("lit_rst_in_ready", 32'(in_ready), 32'd1);
    chk("lit_rst_retire_cnt", 32'(retire_cnt), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = '0;

    // Single word, all loads ready.
    do_reset();
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    out_ready = 3'b111;
    step();
    in_valid = 1'b0;
    chk("a5_out_valid", 32'(out_valid), 32'h7);
    chk("a5_out_data", 32'(out_data), 32'hA5);
    chk("a5_cnt_before", 32'(retire_cnt), 32'd0);
    step();
    chk("a5_retire_cnt", 32'(retire_cnt), 32'd1);
    chk("a5_out_valid_after", 32'(out_valid), 32'd0);

    // Staggered acceptance on 0x3C.
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h3C;
    step();
    in_valid  = 1'b0;
    out_ready = 3'b001;
    step();
    chk("stag_after_l0", 32'(out_valid), 32'b110);
    out_ready = 3'b000;
    step();
    out_ready = 3'b100;
    step();
    chk("stag_after_l2", 32'(out_valid), 32'b010);
    out_ready = 3'b000;
    step();
    chk("stag_no_retire_yet", 32'(retire_cnt), 32'd0);
    chk("stag_data_stable", 32'(out_data), 32'h3C);
    out_ready = 3'b010;
    step();
    chk("stag_after_l1", 32'(out_valid), 32'b000);
    chk("stag_retire", 32'(retire_cnt), 32'd1);
    out_ready = 3'b111;
    step();
    step();
    chk("stag_no_dup", 32'(out_valid), 32'd0);
    chk("stag_cnt_hold", 32'(retire_cnt), 32'd1);

    // Fill both entries with loads stalled.
    do_reset();
    out_ready = 3'b000;
    in_valid  = 1'b1;
    in_data   = 8'h01;
    step();
    in_data = 8'h02;
    step();
    in_data = 8'h03;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("full_in_ready_hold", 32'(in_ready), 32'd0);
    chk("full_head", 32'(out_data), 32'h01);
    out_ready = 3'b111;
    step();
    chk("full_head2", 32'(out_data), 32'h02);
    chk("full_ready_back", 32'(in_ready), 32'd1);
    step();
    chk("full_head3", 32'(out_data), 32'h03);
    in_valid = 1'b0;
    step();
    chk("full_drained", 32'(out_valid), 32'd0);
    chk("full_cnt", 32'(retire_cnt), 32'd3);

    // Full throughput, 20 words.
    do_reset();
    out_ready = 3'b111;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(k);
      step();
      chk("tput_cnt", 32'(retire_cnt), 32'(k));
    end
    in_valid = 1'b0;
    step();
    chk("tput_total", 32'(retire_cnt), 32'd20);

    // Mid-transfer asynchronous reset with head and skid valid.
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h11;
    step();
    in_data = 8'h22;
    step();
    in_valid  = 1'b0;
    out_ready = 3'b101;
    step();
    out_ready = 3'b000;
    chk("arst_pre_ov", 32'(out_valid), 32'b010);
    chk("arst_pre_full", 32'(in_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst       = 1'b0;
    out_ready = 3'b111;
    step();
    step();
    chk("arst_no_stale", 32'(out_valid), 32'd0);
    chk("arst_cnt", 32'(retire_cnt), 32'd0);

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = DW'($urandom);
      for (int i = 0; i < NL; i++) out_ready[i] = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 3'b111;
    step();
    step();
    step();
    chk("rand_drained", 32'(out_valid), 32'd0);

    // Counter wrap: 65535 retires, then one more.
    do_reset();
    out_ready = 3'b111;
    in_valid  = 1'b1;
    for (int c = 0; c < 65535; c++) begin
      in_data = DW'($urandom);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("wrap_ffff", 32'(retire_cnt), 32'hFFFF);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    step();
    in_valid = 1'b0;
    step();
    chk("wrap_zero", 32'(retire_cnt), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
